// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer.
// Owns the PC and the return-address stack and walks each instruction through
// FETCH -> LOAD -> EXEC. The opcode and immediate are presented to the decoder
// for exactly one EXEC cycle; in every other state NOP and a zero immediate are
// presented, so the decoder leaves the datapath idle.
module instr_fetch_unit #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 5,
   parameter int IMM_WIDTH   = 8,
   parameter int STACK_DEPTH = 8
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             HOLD,
   output logic [PC_WIDTH-1:0]              ROM_ADDR,
   input  logic [INSTR_WIDTH+IMM_WIDTH-1:0] ROM_DATA,
   output logic [INSTR_WIDTH-1:0]           INSTRUCTION,
   output logic [IMM_WIDTH-1:0]             IMM,
   output logic                             INSTR_VALID,
   input  logic                             CE_PC,
   input  logic                             PC_SEL,
   input  logic                             STACK_SEL,
   input  logic                             CE_STACK,
   input  logic                             nRW_STACK,
   output logic                             HALTED,
   output logic                             STACK_ERR
);

   localparam int AW   = $clog2(STACK_DEPTH);
   localparam int SP_W = AW + 1;

   localparam logic [INSTR_WIDTH-1:0] OP_NOP   = INSTR_WIDTH'(5'h0C);
   localparam logic [INSTR_WIDTH-1:0] OP_RST   = INSTR_WIDTH'(5'h1F);
   localparam logic [PC_WIDTH-1:0]    PC_ONE   = PC_WIDTH'(1);
   localparam logic [SP_W-1:0]        SP_ONE   = SP_W'(1);
   localparam logic [SP_W-1:0]        SP_FULL  = SP_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_LOAD  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [PC_WIDTH-1:0]    pc_r;
   logic [SP_W-1:0]        sp_r;
   logic [INSTR_WIDTH-1:0] ir_op_r;
   logic [IMM_WIDTH-1:0]   ir_imm_r;
   logic                   valid_r;
   logic                   halted_r;
   logic                   stack_err_r;
   logic [PC_WIDTH-1:0]    stack_r [STACK_DEPTH];

   logic                   push_s;
   logic                   pop_s;
   logic                   sp_empty_s;
   logic                   sp_full_s;
   logic                   exec_live_s;
   logic [PC_WIDTH-1:0]    pc_inc_s;
   logic [PC_WIDTH-1:0]    jmp_tgt_s;
   logic [AW-1:0]          wr_idx_s;
   logic [AW-1:0]          top_idx_s;
   logic [PC_WIDTH-1:0]    nxt_pc_s;
   logic [SP_W-1:0]        nxt_sp_s;
   logic                   err_s;
   logic                   wr_en_s;

   // The IR doubles as the output register: it only holds a real opcode in EXEC.
   assign ROM_ADDR    = pc_r;
   assign INSTRUCTION = ir_op_r;
   assign IMM         = ir_imm_r;
   assign INSTR_VALID = valid_r;
   assign HALTED      = halted_r;
   assign STACK_ERR   = stack_err_r;

   assign push_s      = STACK_SEL & CE_STACK & nRW_STACK;
   assign pop_s       = STACK_SEL & CE_STACK & ~nRW_STACK;
   assign sp_empty_s  = (sp_r == '0);
   assign sp_full_s   = (sp_r == SP_FULL);
   assign pc_inc_s    = pc_r + PC_ONE;
   assign jmp_tgt_s   = ir_imm_r[PC_WIDTH-1:0];
   assign wr_idx_s    = sp_r[AW-1:0];
   assign top_idx_s   = AW'(sp_r - SP_ONE);
   // Stack writes only from a live EXEC cycle that reset does not override.
   assign exec_live_s = (state_r == S_EXEC) && (ir_op_r != OP_RST) && !RESET;

   // Next PC / SP and stack-error decision from the decoder controls in EXEC.
   always_comb begin
      nxt_pc_s = pc_r;
      nxt_sp_s = sp_r;
      err_s    = 1'b0;
      wr_en_s  = 1'b0;
      if (!CE_PC) begin
         if (pop_s && sp_empty_s) begin
            err_s = 1'b1;
         end else if (pop_s) begin
            nxt_sp_s = sp_r - SP_ONE;
            nxt_pc_s = pc_inc_s;
         end else begin
            nxt_pc_s = pc_inc_s;
         end
      end else if (!PC_SEL) begin
         if (push_s && sp_full_s) begin
            err_s = 1'b1;
         end else if (push_s) begin
            nxt_pc_s = jmp_tgt_s;
            nxt_sp_s = sp_r + SP_ONE;
            wr_en_s  = exec_live_s;
         end else begin
            nxt_pc_s = jmp_tgt_s;
         end
      end else begin
         if (pop_s && sp_empty_s) begin
            err_s = 1'b1;
         end else if (pop_s) begin
            nxt_sp_s = sp_r - SP_ONE;
            nxt_pc_s = stack_r[top_idx_s];
         end else begin
            nxt_pc_s = pc_r;
         end
      end
   end

   // Return-address storage; the contents need no reset because SP gates every read.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         stack_r[wr_idx_s] <= pc_inc_s;
      end
   end

   // Sequencer FSM with PC, SP, IR/output and sticky status registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r     <= S_FETCH;
         pc_r        <= '0;
         sp_r        <= '0;
         ir_op_r     <= OP_NOP;
         ir_imm_r    <= '0;
         valid_r     <= 1'b0;
         halted_r    <= 1'b0;
         stack_err_r <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (HOLD) begin
                  state_r <= S_FETCH;
               end else begin
                  state_r <= S_LOAD;
               end
            end
            S_LOAD: begin
               ir_op_r  <= ROM_DATA[INSTR_WIDTH+IMM_WIDTH-1:IMM_WIDTH];
               ir_imm_r <= ROM_DATA[IMM_WIDTH-1:0];
               valid_r  <= 1'b1;
               state_r  <= S_EXEC;
            end
            S_EXEC: begin
               ir_op_r  <= OP_NOP;
               ir_imm_r <= '0;
               valid_r  <= 1'b0;
               if (ir_op_r == OP_RST) begin
                  state_r  <= S_HALT;
                  halted_r <= 1'b1;
               end else if (err_s) begin
                  state_r     <= S_HALT;
                  halted_r    <= 1'b1;
                  stack_err_r <= 1'b1;
               end else begin
                  pc_r    <= nxt_pc_s;
                  sp_r    <= nxt_sp_s;
                  state_r <= S_FETCH;
               end
            end
            S_HALT: begin
               state_r <= S_HALT;
            end
            default: begin
               state_r  <= S_FETCH;
               ir_op_r  <= OP_NOP;
               ir_imm_r <= '0;
               valid_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: a synchronous ROM model plus
// decoder controls driven by hand for each scenario.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        hold;
   logic [7:0]  rom_addr;
   logic [12:0] rom_data;
   logic [4:0]  instruction;
   logic [7:0]  imm;
   logic        instr_valid;
   logic        ce_pc;
   logic        pc_sel;
   logic        stack_sel;
   logic        ce_stack;
   logic        nrw_stack;
   logic        halted;
   logic        stack_err;

   logic [12:0] rom [256];
   int          pass_cnt;
   int          total_cnt;

   instr_fetch_unit dut (
      .CLK         (clk),
      .RESET       (reset),
      .HOLD        (hold),
      .ROM_ADDR    (rom_addr),
      .ROM_DATA    (rom_data),
      .INSTRUCTION (instruction),
      .IMM         (imm),
      .INSTR_VALID (instr_valid),
      .CE_PC       (ce_pc),
      .PC_SEL      (pc_sel),
      .STACK_SEL   (stack_sel),
      .CE_STACK    (ce_stack),
      .nRW_STACK   (nrw_stack),
      .HALTED      (halted),
      .STACK_ERR   (stack_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program ROM: data valid one cycle after the address
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = {5'h0C, 8'h00};
   endtask

   task automatic clear_dec();
      ce_pc = 1'b0; pc_sel = 1'b0; stack_sel = 1'b0; ce_stack = 1'b0; nrw_stack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_dec();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Wait (bounded) for EXEC, report the presented opcode/imm, apply decoder controls.
   task automatic exec_instr(input logic c_pc, input logic c_sel, input logic c_ssel,
                             input logic c_cst, input logic c_nrw,
                             output logic [4:0] op, output logic [7:0] im);
      logic found;
      found = 1'b0;
      op = 5'bxxxxx;
      im = 8'bxxxxxxxx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      if (found) begin
         op = instruction;
         im = imm;
         ce_pc = c_pc; pc_sel = c_sel; stack_sel = c_ssel; ce_stack = c_cst; nrw_stack = c_nrw;
         @(posedge clk);
         #1 clear_dec();
      end
   endtask

   task automatic test_reset();
      clear_rom();
      do_reset();
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", rom_addr); else pass_cnt++;
      total_cnt++;
      if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else pass_cnt++;
      total_cnt++;
      if (instruction !== 5'h0C) $display("FAIL reset_instr: got %h want 0c", instruction); else pass_cnt++;
      total_cnt++;
      if (imm !== 8'h00) $display("FAIL reset_imm: got %h want 00", imm); else pass_cnt++;
      total_cnt++;
      if ({halted, stack_err} !== 2'b00) $display("FAIL reset_status: got %b want 00", {halted, stack_err}); else pass_cnt++;
   endtask

   task automatic test_sequential();
      logic [7:0] exp_addr;
      logic       exp_valid;
      clear_rom();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         exp_addr  = 8'(c / 3);
         exp_valid = ((c % 3) == 2);
         total_cnt++;
         if (rom_addr !== exp_addr) $display("FAIL seq_addr[%0d]: got %h want %h", c, rom_addr, exp_addr); else pass_cnt++;
         total_cnt++;
         if (instr_valid !== exp_valid) $display("FAIL seq_valid[%0d]: got %b want %b", c, instr_valid, exp_valid); else pass_cnt++;
      end
   endtask

   task automatic test_jump();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0] = {5'h0E, 8'h40};
      do_reset();
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      total_cnt++;
      if ({op, im} !== {5'h0E, 8'h40}) $display("FAIL jump_ir: got %h/%h want 0e/40", op, im); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h40) $display("FAIL jump_addr: got %h want 40", rom_addr); else pass_cnt++;
   endtask

   task automatic test_call_ret();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0]     = {5'h0E, 8'h05};
      rom[5]     = {5'h10, 8'h20};
      rom[8'h20] = {5'h11, 8'h00};
      do_reset();
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      exec_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, op, im);
      total_cnt++;
      if (op !== 5'h10) $display("FAIL call_op: got %h want 10", op); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h20) $display("FAIL call_addr: got %h want 20", rom_addr); else pass_cnt++;
      total_cnt++;
      if (dut.sp_r !== 4'd1) $display("FAIL call_sp: got %0d want 1", dut.sp_r); else pass_cnt++;
      exec_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, op, im);
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h06) $display("FAIL ret_addr: got %h want 06", rom_addr); else pass_cnt++;
      total_cnt++;
      if (dut.sp_r !== 4'd0) $display("FAIL ret_sp: got %0d want 0", dut.sp_r); else pass_cnt++;
      total_cnt++;
      if ({halted, stack_err} !== 2'b00) $display("FAIL ret_status: got %b want 00", {halted, stack_err}); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0] = {5'h10, 8'h30};
      for (int k = 0; k < 8; k++) rom[8'h30 + k] = {5'h10, 8'(8'h31 + k)};
      do_reset();
      for (int k = 0; k < 8; k++) exec_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, op, im);
      @(negedge clk);
      total_cnt++;
      if ({rom_addr, halted, stack_err} !== {8'h37, 2'b00}) $display("FAIL ovf_8deep: got %h/%b want 37/00", rom_addr, {halted, stack_err}); else pass_cnt++;
      total_cnt++;
      if (dut.sp_r !== 4'd8) $display("FAIL ovf_sp8: got %0d want 8", dut.sp_r); else pass_cnt++;
      exec_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, op, im);
      repeat (4) @(negedge clk);
      total_cnt++;
      if ({halted, stack_err} !== 2'b11) $display("FAIL ovf_status: got %b want 11", {halted, stack_err}); else pass_cnt++;
      total_cnt++;
      if ({rom_addr, instr_valid} !== {8'h37, 1'b0}) $display("FAIL ovf_frozen: got %h/%b want 37/0", rom_addr, instr_valid); else pass_cnt++;
      total_cnt++;
      if (dut.sp_r !== 4'd8) $display("FAIL ovf_sp: got %0d want 8", dut.sp_r); else pass_cnt++;
   endtask

   task automatic test_underflow();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0] = {5'h11, 8'h00};
      do_reset();
      exec_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, op, im);
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({halted, stack_err} !== 2'b11) $display("FAIL udf_status: got %b want 11", {halted, stack_err}); else pass_cnt++;
      total_cnt++;
      if (rom_addr !== 8'h00) $display("FAIL udf_addr: got %h want 00", rom_addr); else pass_cnt++;
   endtask

   task automatic test_ret_no_pop();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0] = {5'h11, 8'h00};
      do_reset();
      exec_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op, im);
      @(negedge clk);
      total_cnt++;
      if ({rom_addr, halted, stack_err} !== {8'h00, 2'b00}) $display("FAIL hold_in_place: got %h/%b want 00/00", rom_addr, {halted, stack_err}); else pass_cnt++;
   endtask

   task automatic test_halt_opcode();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[1] = {5'h1F, 8'h33};
      do_reset();
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      total_cnt++;
      if (op !== 5'h1F) $display("FAIL halt_op: got %h want 1f", op); else pass_cnt++;
      repeat (4) @(negedge clk);
      total_cnt++;
      if ({halted, stack_err} !== 2'b10) $display("FAIL halt_status: got %b want 10", {halted, stack_err}); else pass_cnt++;
      total_cnt++;
      if ({instruction, instr_valid} !== {5'h0C, 1'b0}) $display("FAIL halt_nop: got %h/%b want 0c/0", instruction, instr_valid); else pass_cnt++;
      total_cnt++;
      if (rom_addr !== 8'h01) $display("FAIL halt_pc: got %h want 01", rom_addr); else pass_cnt++;
      do_reset();
      @(negedge clk);
      total_cnt++;
      if ({rom_addr, halted} !== {8'h00, 1'b0}) $display("FAIL halt_reset: got %h/%b want 00/0", rom_addr, halted); else pass_cnt++;
   endtask

   task automatic test_hold();
      logic [4:0] op;
      logic [7:0] im;
      int         bad;
      clear_rom();
      hold = 1'b1;
      do_reset();
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rom_addr !== 8'h00 || instr_valid !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles want 0", bad); else pass_cnt++;
      hold = 1'b0;
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h01) $display("FAIL hold_release: got %h want 01", rom_addr); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [4:0] op;
      logic [7:0] im;
      clear_rom();
      rom[0]     = {5'h0E, 8'hFF};
      rom[8'hFF] = {5'h10, 8'h50};
      rom[8'h50] = {5'h11, 8'h00};
      do_reset();
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      @(negedge clk);
      total_cnt++;
      if (rom_addr !== 8'h00) $display("FAIL wrap_seq: got %h want 00", rom_addr); else pass_cnt++;
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, im);
      exec_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, op, im);
      exec_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, op, im);
      @(negedge clk);
      total_cnt++;
      if ({rom_addr, stack_err} !== {8'h00, 1'b0}) $display("FAIL wrap_push: got %h/%b want 00/0", rom_addr, stack_err); else pass_cnt++;
   endtask

   task automatic test_reset_mid_exec();
      logic found;
      clear_rom();
      rom[0] = {5'h10, 8'h20};
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (!found) $display("FAIL midreset_exec: got no EXEC want EXEC"); else pass_cnt++;
      ce_pc = 1'b1; stack_sel = 1'b1; ce_stack = 1'b1; nrw_stack = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      clear_dec();
      @(negedge clk);
      total_cnt++;
      if ({rom_addr, instr_valid} !== {8'h00, 1'b0}) $display("FAIL midreset_pc: got %h/%b want 00/0", rom_addr, instr_valid); else pass_cnt++;
      total_cnt++;
      if (dut.sp_r !== 4'd0) $display("FAIL midreset_sp: got %0d want 0", dut.sp_r); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      hold      = 1'b0;
      clear_dec();
      clear_rom();
      test_reset();
      test_sequential();
      test_jump();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_ret_no_pop();
      test_halt_opcode();
      test_hold();
      test_wrap();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
